fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq_if.sv | 45 ++++
 rtl/fir_mac_seq.sv | 182 ++++++++++++++++++
 tb/tb_fir_mac_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_seq_if.sv
// ---------------------------------------------------------------------------
// fir_mac_seq_if -- sample, coefficient and result signals of fir_mac_seq.
//   bank_sel         coefficient bank used for the next accepted sample
//   in_valid/ready   sample handshake, x_in is the signed sample
//   flush            clears the delay line while the filter is idle
//   coef_we/bank/addr/data  coefficient write port, coef_err = write rejected
//   out_valid/ready  result handshake, y_out signed result, sat = clamped
// master: the side that feeds samples and consumes results (testbench/host).
// slave : the filter itself.
// ---------------------------------------------------------------------------
interface fir_mac_seq_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16
);
  localparam int AW = $clog2(TAPS);

  logic [1:0]               bank_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic                     flush;
  logic                     coef_we;
  logic [1:0]               coef_bank;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_err;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  y_out;
  logic                     sat;

  modport master (
    output bank_sel, in_valid, x_in, flush, coef_we, coef_bank, coef_addr,
           coef_data, out_ready,
    input  in_ready, coef_err, out_valid, y_out, sat
  );

  modport slave (
    input  bank_sel, in_valid, x_in, flush, coef_we, coef_bank, coef_addr,
           coef_data, out_ready,
    output in_ready, coef_err, out_valid, y_out, sat
  );
endinterface

// File: rtl/fir_mac_seq.sv
// ---------------------------------------------------------------------------
// fir_mac_seq -- time-multiplexed FIR filter, one multiply-accumulate per
// clock, four switchable coefficient banks.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fir_mac_seq_if.slave (sample in, coefficient write, result out)
// Optional feature macro: FIR_SAT_EN
//   defined   -> result clamped to the OUT_W signed range, sat flags clamping
//   undefined -> result wraps to its low OUT_W bits, sat is always 0
// Timing: a sample accepted at edge N gives out_valid from edge N+TAPS+1.
// The products are registered, so the MAC phase spends TAPS cycles forming
// products plus one cycle folding the last product into the result.
// ---------------------------------------------------------------------------
module fir_mac_seq #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15
) (
  input logic          clk,
  input logic          rst_n,
  fir_mac_seq_if.slave bus
);

  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam int RW    = ACC_W + 1;
  localparam int AW    = $clog2(TAPS);
  localparam int KW    = $clog2(TAPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);

  logic [1:0]               r_state;
  logic [KW-1:0]            r_tap;
  logic [1:0]               r_bank;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [PW-1:0]     r_prod;
  logic                     r_prod_vld;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_y;
  logic                     r_sat;
  logic                     r_coef_err;
  logic signed [DATA_W-1:0] r_d    [TAPS];
  logic signed [COEF_W-1:0] r_coef [4][TAPS];

  logic [AW-1:0]            w_idx;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_acc_fin;
  logic signed [RW-1:0]     w_rnd;
  logic signed [OUT_W-1:0]  w_y;
  logic                     w_sat;
  logic                     w_coef_hit;

  // Tap index is only meaningful below TAPS; the fold cycle reads tap 0 harmlessly.
  assign w_idx      = (r_tap < KW'(TAPS)) ? r_tap[AW-1:0] : {AW{1'b0}};
  assign w_prod     = r_d[w_idx] * r_coef[r_bank][w_idx];
  assign w_prod_ext = {{(ACC_W-PW){r_prod[PW-1]}}, r_prod};
  assign w_acc_fin  = r_acc + w_prod_ext;
  assign w_rnd      = {w_acc_fin[ACC_W-1], w_acc_fin} + RND;

  // A write aimed at the bank the running sample uses would corrupt it.
  assign w_coef_hit = bus.coef_we && (r_state != S_IDLE) && (bus.coef_bank == r_bank);

`ifdef FIR_SAT_EN
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = RW'(-(64'sd1 <<< (OUT_W - 1)));
  logic signed [RW-1:0] w_r;
  assign w_r = w_rnd >>> SHIFT;

  // Clamp the rounded result into the output range.
  always_comb begin
    w_y   = w_r[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_r > MAXV) begin
      w_y   = MAXV[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_r < MINV) begin
      w_y   = MINV[OUT_W-1:0];
      w_sat = 1'b1;
    end else begin
      w_y   = w_r[OUT_W-1:0];
      w_sat = 1'b0;
    end
  end
`else
  assign w_y   = OUT_W'(w_rnd >>> SHIFT);
  assign w_sat = 1'b0;
`endif

  // Control FSM, delay line, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tap       <= {KW{1'b0}};
      r_bank      <= 2'd0;
      r_acc       <= {ACC_W{1'b0}};
      r_prod      <= {PW{1'b0}};
      r_prod_vld  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= {OUT_W{1'b0}};
      r_sat       <= 1'b0;
      for (int k = 0; k < TAPS; k++) r_d[k] <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            // flush together with a sample: the sample enters a zeroed line
            r_d[0] <= bus.x_in;
            for (int k = 1; k < TAPS; k++)
              r_d[k] <= bus.flush ? {DATA_W{1'b0}} : r_d[k-1];
            r_bank     <= bus.bank_sel;
            r_acc      <= {ACC_W{1'b0}};
            r_tap      <= {KW{1'b0}};
            r_prod_vld <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_MAC;
          end else begin
            if (bus.flush) begin
              for (int k = 0; k < TAPS; k++) r_d[k] <= {DATA_W{1'b0}};
            end
            r_in_ready <= 1'b1;
          end
        end
        S_MAC: begin
          if (r_tap < KW'(TAPS)) begin
            r_prod     <= w_prod;
            r_prod_vld <= 1'b1;
            if (r_prod_vld) r_acc <= w_acc_fin;
            r_tap      <= r_tap + KW'(1);
          end else begin
            // fold cycle: last product joins the sum, result is registered
            r_acc       <= w_acc_fin;
            r_y         <= w_y;
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient store and write-rejection flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef_err <= 1'b0;
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < TAPS; k++) r_coef[b][k] <= {COEF_W{1'b0}};
    end else begin
      r_coef_err <= w_coef_hit;
      if (bus.coef_we && !w_coef_hit && ({1'b0, bus.coef_addr} < (AW+1)'(TAPS)))
        r_coef[bus.coef_bank][bus.coef_addr] <= bus.coef_data;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y_out     = r_y;
  assign bus.sat       = r_sat;
  assign bus.coef_err  = r_coef_err;

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq (TAPS=8, SHIFT=15, 16-bit data/coef/out).
module tb_fir_mac_seq;
  localparam int TAPS = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fir_mac_seq_if #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(16)) bus ();

  fir_mac_seq #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(16), .SHIFT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_coef(input logic [1:0] b, input logic [2:0] a,
                           input logic signed [15:0] d);
    bus.coef_we   = 1'b1;
    bus.coef_bank = b;
    bus.coef_addr = a;
    bus.coef_data = d;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic accept(input logic signed [15:0] x, input logic [1:0] b,
                        input logic fl);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.x_in     = x;
    bus.bank_sel = b;
    bus.flush    = fl;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // base = cycles already elapsed since the accepting edge
  task automatic wait_out(input int base);
    int lat;
    lat = base;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, TAPS + 1);
  endtask

  task automatic run(input string tag, input logic signed [15:0] x,
                     input logic [1:0] b, input logic fl,
                     input logic signed [15:0] ey, input logic es);
    accept(x, b, fl);
    wait_out(0);
    check({tag, "_y"}, bus.y_out, ey);
    check({tag, "_sat"}, bus.sat, es);
    tick();
  endtask

  task automatic load_ramp_bank0();
    for (int k = 0; k < TAPS; k++) load_coef(2'd0, 3'(k), 16'(1000 * (k + 1)));
  endtask

  task automatic impulse_seq(input string tag);
    run(tag, 16'sd16384, 2'd0, 1'b0, 16'sd500, 1'b0);
    for (int j = 1; j < TAPS; j++)
      run(tag, 16'sd0, 2'd0, 1'b0, 16'(500 * (j + 1)), 1'b0);
  endtask

  initial begin
    int vcount;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.bank_sel  = 2'd0;
    bus.in_valid  = 1'b0;
    bus.x_in      = 16'sd0;
    bus.flush     = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_bank = 2'd0;
    bus.coef_addr = 3'd0;
    bus.coef_data = 16'sd0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y_out, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_coef_err", bus.coef_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", bus.in_ready, 1);

    // impulse through ramp coefficients: 500,1000,...,4000
    load_ramp_bank0();
    impulse_seq("imp");

    // back-pressure: result held with out_ready low for 10 cycles
    bus.out_ready = 1'b0;
    accept(16'sd16384, 2'd0, 1'b0);
    wait_out(0);
    check("hold_y0", bus.y_out, 500);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_y", bus.y_out, 500);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    check("consume_valid", bus.out_valid, 0);
    check("consume_in_ready", bus.in_ready, 1);

    // coefficient writes while the MAC runs on bank 0
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    accept(16'sd0, 2'd0, 1'b0);
    tick();
    bus.coef_we   = 1'b1;
    bus.coef_bank = 2'd0;
    bus.coef_addr = 3'd0;
    bus.coef_data = 16'sd5;
    tick();
    check("coef_err_pulse", bus.coef_err, 1);
    bus.coef_bank = 2'd2;
    bus.coef_data = 16'sd77;
    tick();
    check("coef_err_other_bank", bus.coef_err, 0);
    bus.coef_we = 1'b0;
    wait_out(3);
    check("mac_wr_y", bus.y_out, 0);
    tick();
    // c0 of bank 0 must still be 1000: 16384*1000/2^15 = 500 (5 would give 3)
    run("bank0_kept", 16'sd16384, 2'd0, 1'b0, 16'sd500, 1'b0);
    // bank 2 = {77,0,...}: (16384*77 + 16384) >> 15 = 39
    run("bank2_new", 16'sd16384, 2'd2, 1'b0, 16'sd39, 1'b0);

    // full-scale: c = 32767, x = 32767; flush+valid zeroes the older taps
    for (int k = 0; k < TAPS; k++) load_coef(2'd3, 3'(k), 16'sd32767);
    // one term: (1073676289 + 16384) >> 15 = 32766
    run("fs1", 16'sd32767, 2'd3, 1'b1, 16'sd32766, 1'b0);
`ifdef FIR_SAT_EN
    run("fs2", 16'sd32767, 2'd3, 1'b0, 16'sd32767, 1'b1);
`else
    // two terms: 65532 wraps to -4
    run("fs2", 16'sd32767, 2'd3, 1'b0, -16'sd4, 1'b0);
`endif
    for (int j = 3; j < TAPS; j++) begin
      accept(16'sd32767, 2'd3, 1'b0);
      wait_out(0);
      tick();
    end
`ifdef FIR_SAT_EN
    run("fs8", 16'sd32767, 2'd3, 1'b0, 16'sd32767, 1'b1);
`else
    // eight terms: (2^33 - 2^19 + 8 + 2^14) >> 15 = 262128 = 0x3FFF0 -> -16
    run("fs8", 16'sd32767, 2'd3, 1'b0, -16'sd16, 1'b0);
`endif

    // reset during MAC cycle 3
    accept(16'sd32767, 2'd3, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.out_valid === 1'b1) vcount++;
    end
    check("midrst_no_valid", vcount, 0);
    // delay line must be clear: the impulse sequence comes out exactly
    load_ramp_bank0();
    impulse_seq("post_rst");
    // bank 3 coefficients were cleared by the reset
    run("coef_rst", 16'sd16384, 2'd3, 1'b0, 16'sd0, 1'b0);

    // flush after eight nonzero samples leaves no residue
    for (int j = 0; j < TAPS; j++) begin
      accept(16'sd1000, 2'd0, 1'b0);
      wait_out(0);
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    impulse_seq("post_flush");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
